// File: rtl/ram_port_arbiter_if.sv
// Requester-side command/response bundle for the buffer RAM port-A arbiter.
// The master modport is the requester and the slave modport is the arbiter.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing buffer RAM port A between the UART receive path (r0)
// and the systolic feed/readback path (r1); read data is routed back by requester tag.
module ram_port_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave r0,
  ram_port_arbiter_if.slave r1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  logic       prio;
  logic [1:0] req;
  logic [1:0] gnt;
  cmd_t [1:0] cmd;
  cmd_t       sel;
  logic       sel_id;
  logic       accept;
  logic       issue_rd;

  // Read tracker: stage 1 is the RAM command cycle, stage 2 is the data-return cycle.
  logic [2:1] vld_pipe;
  logic [2:1] id_pipe;

  assign req    = {r1.req, r0.req};
  assign cmd[0] = {r0.we, r0.addr, r0.wdata};
  assign cmd[1] = {r1.we, r1.addr, r1.wdata};

  // A lone requester always wins; prio only breaks ties.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (req[0] && (!req[1] || !prio)) gnt[0] = 1'b1;
      else if (req[1])                  gnt[1] = 1'b1;
    end
  end

  assign accept   = |gnt;
  assign sel_id   = gnt[1];
  assign sel      = cmd[sel_id];
  assign issue_rd = accept && !sel.we;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= 1'b0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      ram_en <= accept;
      ram_we <= accept && sel.we;
      if (accept) begin
        ram_addr <= sel.addr;
        ram_din  <= sel.wdata;
        prio     <= ~sel_id;
      end
      vld_pipe <= {vld_pipe[1], issue_rd};
      id_pipe  <= {id_pipe[1], sel_id};
    end
  end

  assign r0.gnt    = gnt[0];
  assign r1.gnt    = gnt[1];
  assign r0.rvalid = vld_pipe[2] && !id_pipe[2];
  assign r1.rvalid = vld_pipe[2] &&  id_pipe[2];
  assign r0.rdata  = ram_dout;
  assign r1.rdata  = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a registered-read RAM model on port A.
module tb_ram_port_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       ram_en, ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [7:0] mem [8];
  int checks = 0;
  int errors = 0;

  ram_port_arbiter_if #(.ADDR_W(3), .DATA_W(8)) r0_if ();
  ram_port_arbiter_if #(.ADDR_W(3), .DATA_W(8)) r1_if ();

  ram_port_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .r0(r0_if), .r1(r1_if),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic q, input logic w, input logic [2:0] a, input logic [7:0] d);
    r0_if.req = q; r0_if.we = w; r0_if.addr = a; r0_if.wdata = d;
  endtask

  task automatic drv1(input logic q, input logic w, input logic [2:0] a, input logic [7:0] d);
    r1_if.req = q; r1_if.we = w; r1_if.addr = a; r1_if.wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [1:0] eg, ev;
    rst = 1'b1;
    drv0(1, 0, 0, 0);
    drv1(1, 0, 0, 0);

    // reset held 3 cycles with both requesting
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", 32'({r1_if.gnt, r0_if.gnt}), 32'(2'b00));
      chk("rst_en",  32'({ram_en, ram_we}), 32'(2'b00));
      chk("rst_rv",  32'({r1_if.rvalid, r0_if.rvalid}), 32'(2'b00));
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_gnt", 32'({r1_if.gnt, r0_if.gnt}), 32'(2'b01));
    tick();
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    tick();
    @(negedge clk);
    chk("first_rv", 32'({r1_if.rvalid, r0_if.rvalid, r0_if.rdata}), 32'({2'b01, 8'h10}));
    tick();

    // r0 write 0xA5 to 3, then read 3
    drv0(1, 1, 3, 8'hA5);
    @(negedge clk);
    chk("wr_gnt", 32'(r0_if.gnt), 32'(1));
    tick();
    drv0(1, 0, 3, 0);
    @(negedge clk);
    chk("wr_cmd", 32'({ram_en, ram_we, ram_addr, ram_din}), 32'({1'b1, 1'b1, 3'd3, 8'hA5}));
    chk("rd_gnt", 32'(r0_if.gnt), 32'(1));
    tick();
    drv0(0, 0, 0, 0);
    @(negedge clk);
    chk("rd_cmd", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, 1'b0, 3'd3}));
    chk("rd_early", 32'({r1_if.rvalid, r0_if.rvalid}), 32'(2'b00));
    tick();
    @(negedge clk);
    chk("rd_rv", 32'({r1_if.rvalid, r0_if.rvalid}), 32'(2'b01));
    chk("rd_data", 32'(r0_if.rdata), 32'(8'hA5));
    tick();
    @(negedge clk);
    chk("rd_once", 32'({r0_if.rvalid, ram_en}), 32'(2'b00));

    // r1 alone writes 0x55 to 5 (leaves prio on r0), then 6 cycles of dual reads
    drv1(1, 1, 5, 8'h55);
    tick();
    drv1(0, 0, 0, 0);
    for (int c = 0; c <= 8; c++) begin
      drv0(c < 6, 0, 3, 0);
      drv1(c < 6, 0, 5, 0);
      eg = (c < 6) ? ((c % 2) ? 2'b10 : 2'b01) : 2'b00;
      ev = (c >= 2 && c < 8) ? ((c % 2) ? 2'b10 : 2'b01) : 2'b00;
      @(negedge clk);
      chk("rr_gnt", 32'({r1_if.gnt, r0_if.gnt}), 32'(eg));
      chk("rr_rv", 32'({r1_if.rvalid, r0_if.rvalid}), 32'(ev));
      if (ev == 2'b01) chk("rr_d0", 32'(r0_if.rdata), 32'(8'hA5));
      if (ev == 2'b10) chk("rr_d1", 32'(r1_if.rdata), 32'(8'h55));
      tick();
    end

    // r0 streams writes 0..7 while r1 rereads address 0; r1 leads by one cycle
    for (int c = 0; c <= 18; c++) begin
      drv0(c >= 1 && c <= 15, 1, 3'(c / 2), 8'(32'hC0 + c / 2));
      drv1(c <= 16, 0, 0, 0);
      eg = (c <= 16) ? ((c % 2) ? 2'b01 : 2'b10) : 2'b00;
      ev = (c >= 2 && c % 2 == 0) ? 2'b10 : 2'b00;
      @(negedge clk);
      chk("mx_gnt", 32'({r1_if.gnt, r0_if.gnt}), 32'(eg));
      chk("mx_rv", 32'({r1_if.rvalid, r0_if.rvalid}), 32'(ev));
      if (ev == 2'b10) chk("mx_d1", 32'(r1_if.rdata), (c == 2) ? 32'h10 : 32'hC0);
      tick();
    end

    // dump all 8 words back-to-back through r0 (covers address 7 vs 0 independence)
    for (int c = 0; c <= 9; c++) begin
      drv0(c < 8, 0, 3'(c), 0);
      drv1(0, 0, 0, 0);
      @(negedge clk);
      chk("dump_gnt", 32'(r0_if.gnt), 32'(c < 8));
      chk("dump_rv", 32'({r1_if.rvalid, r0_if.rvalid}), (c >= 2) ? 32'h1 : 32'h0);
      if (c >= 2) chk("dump_d", 32'(r0_if.rdata), 32'hC0 + 32'(c - 2));
      tick();
    end

    // reset one edge after an r1 read is accepted
    drv0(0, 0, 0, 0);
    drv1(1, 0, 0, 0);
    tick();
    rst = 1'b1;
    drv0(1, 0, 0, 0);
    @(negedge clk);
    chk("mid_gnt", 32'({r1_if.gnt, r0_if.gnt}), 32'(2'b00));
    tick();
    @(negedge clk);
    chk("mid_rv", 32'({r1_if.rvalid, r0_if.rvalid}), 32'(2'b00));
    chk("mid_regs", 32'({ram_en, ram_we, ram_addr, ram_din}), 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rv2", 32'({r1_if.rvalid, r0_if.rvalid}), 32'(2'b00));
    chk("mid_gnt2", 32'({r1_if.gnt, r0_if.gnt}), 32'(2'b01));
    tick();
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
